lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store port between the RV32I core datapath and a handshaked data memory. It accepts a load or store from the core and issues a word-aligned request with byte enables to memory. For loads it returns the extracted, sign/zero-extended result on `read_data`, which feeds the ReadData leg of the writeback result-select mux. The core is stalled until the access completes, errors, or times out.

## Interface
Parameters:
- `WIDTH`, 32: data/address width; only 32 is supported.
- `TIMEOUT`, 255: maximum number of BUSY cycles waited for `m_ack` before aborting; range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  core load request, held until `done`.
- `mem_write`  in  1  core store request, held until `done`.
- `funct3`  in  3  RV32I load/store funct3.
- `addr`  in  WIDTH  byte address (ALUResult).
- `wdata`  in  WIDTH  store data (rs2).
- `stall`  out  1  freeze the core PC and pipeline.
- `done`  out  1  one-cycle completion pulse.
- `read_data`  out  WIDTH  formatted load result (ReadData).
- `misalign`  out  1  valid with `done`; access was misaligned and was not issued.
- `bus_err`  out  1  valid with `done`; memory timed out.
- `m_req`  out  1  memory request.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  WIDTH  word address, with `[1:0]` always 0.
- `m_wdata`  out  WIDTH  lane-replicated store data.
- `m_be`  out  4  byte enables.
- `m_ack`  in  1  memory accepted/completed; `m_rdata` is valid in the same cycle.
- `m_rdata`  in  WIDTH  memory read word.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: a request is any of `mem_read|mem_write`.
  - Aligned request: latch the request fields, go to BUSY.
  - Misaligned request: go to DONE with `misalign`=1 and no memory access.
  - Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Both request inputs high: treated as a store.
- BUSY:
  - `m_req`=1, with `m_we`/`m_addr`/`m_wdata`/`m_be` held stable from the latched values.
  - On `m_ack`: loads capture the formatted `m_rdata` into `read_data`; go to DONE.
  - Timeout counter increments each BUSY cycle without ack. If the count reaches `TIMEOUT`: drop `m_req`, set `read_data`=0 for loads, go to DONE with `bus_err`=1.
- DONE: `done`=1 for exactly one cycle, then IDLE. Requests are not sampled in DONE.
- `stall` = BUSY, OR (IDLE and request present). `stall` is 0 in DONE so the core advances at the end of DONE.
- Size from `funct3[1:0]`: 00 byte, 01 half, 1x word. `funct3[2]`=1 means zero-extend byte/half loads.
- Store lanes:
  - Byte: `m_be`=1<<`addr[1:0]`, `m_wdata`={4{wdata[7:0]}}.
  - Half: `m_be`=0011 or 1100 by `addr[1]`, `m_wdata`={2{wdata[15:0]}}.
  - Word: `m_be`=1111.
- Loads drive `m_be` by the same rules; `m_we`=0.
- Load extract: select the byte or half by `addr[1:0]` from `m_rdata`, then sign- or zero-extend to 32 bits.
- `read_data` holds its value until the next load completes. Stores, misaligned accesses and bus errors on stores leave it unchanged.
- `m_ack` is ignored when `m_req`=0.

## Timing
- Reset values: state IDLE, `read_data`=0, and `done`/`misalign`/`bus_err`/`m_req`/`m_we`/`m_be`/`m_addr`/`m_wdata`=0. Timeout counter = 0.
- `stall` is combinational from the inputs in IDLE; all other outputs are registered.
- Zero-wait memory (ack in the first BUSY cycle): request in cycle 0, `m_req` in cycle 1, `done` in cycle 2.
  - `stall` is high in cycles 0–1.
  - `read_data` is valid from cycle 2.
- N wait cycles add N cycles to BUSY.
- Misaligned: request in cycle 0, `done`+`misalign` in cycle 1; `stall` is high in cycle 0 only.
- Timeout: `m_req` is high for `TIMEOUT` cycles; `done`+`bus_err` follow on the next cycle.
- An ack arriving in the same cycle the count reaches `TIMEOUT` wins: the access is treated as successful.
- Reset asserted mid-BUSY: `m_req` drops immediately, no `done` is produced, and the FSM returns to IDLE.

## Test plan
- LW at `addr`=0x100 with zero-wait memory returning 0xDEADBEEF:
  - `m_addr`=0x100, `m_be`=1111, `m_req` for 1 cycle.
  - `done` in cycle 2, `read_data`=0xDEADBEEF, `stall` high 2 cycles.
- LB/LBU/LH/LHU at `addr`=0x103/0x103/0x102/0x102 with `m_rdata`=0x80F17F01:
  - `read_data` = 0xFFFFFF80 / 0x00000080 / 0xFFFF80F1 / 0x000080F1.
- SB at `addr`=0x201 with `wdata`=0x000000AB → `m_addr`=0x200, `m_be`=0010, `m_wdata`=0xABABABAB, `m_we`=1; `read_data` unchanged.
- SH at `addr`=0x203 → no `m_req`; `done`+`misalign` in cycle 1.
- LW with `TIMEOUT`=4 and no ack:
  - `m_req` high for 4 cycles, then `done`+`bus_err`, `read_data`=0.
  - Rerun with ack on the 4th cycle: success, no `bus_err`.
- Reset asserted while BUSY with 3 wait states → `m_req` falls asynchronously and no `done` is produced. A following LW completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store port: turns an RV32I core load/store into a word-aligned, handshaked memory
// request with byte enables, and formats load data for the writeback mux.
module lsu_mem_port #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] read_data,
   output logic             misalign,
   output logic             bus_err,
   output logic             m_req,
   output logic             m_we,
   output logic [WIDTH-1:0] m_addr,
   output logic [WIDTH-1:0] m_wdata,
   output logic [3:0]       m_be,
   input  logic             m_ack,
   input  logic [WIDTH-1:0] m_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             m_req_q, m_req_d;
   logic             m_we_q, m_we_d;
   logic [WIDTH-1:0] m_addr_q, m_addr_d;
   logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
   logic [3:0]       m_be_q, m_be_d;
   logic [WIDTH-1:0] read_data_q, read_data_d;
   logic             done_q, done_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;
   logic             is_load_q, is_load_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [1:0]       off_q, off_d;

   logic             req;
   logic             mis;
   logic [3:0]       be_n;
   logic [WIDTH-1:0] wd_n;

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      unique case (sz)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      req = mem_read | mem_write;
      mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00);
      unique case (funct3[1:0])
         2'b00: begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{wdata[15:0]}};
         end
         default: begin
            be_n = 4'b1111;
            wd_n = wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      m_req_d     = m_req_q;
      m_we_d      = m_we_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_be_d      = m_be_q;
      read_data_d = read_data_q;
      is_load_d   = is_load_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      done_d      = 1'b0;
      misalign_d  = 1'b0;
      bus_err_d   = 1'b0;
      stall       = 1'b0;
      unique case (state_q)
         StIdle: begin
            stall = req;
            if (req && mis) begin
               state_d    = StDone;
               done_d     = 1'b1;
               misalign_d = 1'b1;
            end else if (req) begin
               state_d   = StBusy;
               cnt_d     = 8'd0;
               m_req_d   = 1'b1;
               m_we_d    = mem_write;  // store wins when both are asserted
               m_addr_d  = {addr[WIDTH-1:2], 2'b00};
               m_be_d    = be_n;
               m_wdata_d = wd_n;
               is_load_d = ~mem_write;
               size_d    = funct3[1:0];
               uns_d     = funct3[2];
               off_d     = addr[1:0];
            end
         end
         StBusy: begin
            stall = 1'b1;
            // An ack in the same cycle the timeout is reached still counts as success.
            if (m_ack && m_req_q) begin
               state_d = StDone;
               done_d  = 1'b1;
               m_req_d = 1'b0;
               if (is_load_q) read_data_d = fmt_load(m_rdata, off_q, size_q, uns_q);
            end else if (cnt_q + 8'd1 == TimeoutCnt) begin
               state_d   = StDone;
               done_d    = 1'b1;
               bus_err_d = 1'b1;
               m_req_d   = 1'b0;
               if (is_load_q) read_data_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         m_be_q      <= 4'b0000;
         read_data_q <= '0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         is_load_q   <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m_req_q     <= m_req_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_be_q      <= m_be_d;
         read_data_q <= read_data_d;
         done_q      <= done_d;
         misalign_q  <= misalign_d;
         bus_err_q   <= bus_err_d;
         is_load_q   <= is_load_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
      end
   end

   assign done      = done_q;
   assign read_data = read_data_q;
   assign misalign  = misalign_q;
   assign bus_err   = bus_err_q;
   assign m_req     = m_req_q;
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign m_be      = m_be_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: table-driven accesses against a small memory
// responder, expected results queued at issue and compared on completion.
module tb_lsu_mem_port;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, misalign, bus_err;
   logic [31:0] read_data;
   logic        m_req, m_we, m_ack;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;

   always #5 clk = ~clk;

   lsu_mem_port #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .read_data(read_data), .misalign(misalign), .bus_err(bus_err), .m_req(m_req),
      .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack),
      .m_rdata(m_rdata)
   );

   typedef struct {
      logic rd; logic wr; logic [2:0] f3;
      logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int waits;  // -1: never ack
      logic [31:0] exp_rd; logic [3:0] exp_be; logic exp_mis; logic exp_berr;
   } vec_t;

   typedef struct {
      logic [31:0] rd_data; logic mis; logic berr;
      int done_cyc; int req_cyc; int stall_cyc;
      logic [31:0] maddr; logic [31:0] mwdata; logic [3:0] be; logic we;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic run(input vec_t v, input string tag);
      exp_t        e;
      int          req_cnt, stall_cnt, done_at;
      bit          seen;
      logic [31:0] c_addr, c_wd, c_rd;
      logic [3:0]  c_be;
      logic        c_we, c_mis, c_berr;
      e.mis = v.exp_mis; e.berr = v.exp_berr; e.rd_data = v.exp_rd;
      if (v.exp_mis) begin
         e.req_cyc = 0; e.done_cyc = 1; e.stall_cyc = 1;
      end else if (v.exp_berr) begin
         e.req_cyc = TO; e.done_cyc = TO + 1; e.stall_cyc = TO + 1;
      end else begin
         e.req_cyc = v.waits + 1; e.done_cyc = v.waits + 2; e.stall_cyc = v.waits + 2;
      end
      e.maddr = {v.addr[31:2], 2'b00}; e.be = v.exp_be; e.we = v.wr;
      case (v.f3[1:0])
         2'b00:   e.mwdata = {4{v.wdata[7:0]}};
         2'b01:   e.mwdata = {2{v.wdata[15:0]}};
         default: e.mwdata = v.wdata;
      endcase
      sb_q.push_back(e);

      mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
      m_ack = 1'b0;
      req_cnt = 0; stall_cnt = 0; done_at = -1; seen = 0;
      c_addr = '0; c_wd = '0; c_rd = '0; c_be = '0; c_we = 0; c_mis = 0; c_berr = 0;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
         if (m_req) begin
            m_ack   = (v.waits >= 0) && (req_cnt == v.waits);
            m_rdata = v.rdata;
         end else begin
            m_ack = 1'b0;
         end
         @(negedge clk);
         if (stall) stall_cnt++;
         if (m_req) begin
            if (req_cnt == 0) begin
               c_addr = m_addr; c_be = m_be; c_wd = m_wdata; c_we = m_we;
            end
            req_cnt++;
         end
         if (done) begin
            seen = 1; done_at = cyc; c_mis = misalign; c_berr = bus_err; c_rd = read_data;
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0; mem_write = 1'b0; m_ack = 1'b0;

      e = sb_q.pop_front();
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " done_cycle"}, done_at, e.done_cyc);
      chk({tag, " req_cycles"}, req_cnt, e.req_cyc);
      chk({tag, " stall_cycles"}, stall_cnt, e.stall_cyc);
      chk({tag, " misalign"}, 32'(c_mis), 32'(e.mis));
      chk({tag, " bus_err"}, 32'(c_berr), 32'(e.berr));
      chk({tag, " read_data"}, c_rd, e.rd_data);
      if (e.req_cyc > 0) begin
         chk({tag, " m_addr"}, c_addr, e.maddr);
         chk({tag, " m_be"}, 32'(c_be), 32'(e.be));
         chk({tag, " m_we"}, 32'(c_we), 32'(e.we));
         if (e.we) chk({tag, " m_wdata"}, c_wd, e.mwdata);
      end
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t post;
      int   done_hits;
      vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 0, 0};
      vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80F17F01, 0, 32'hFFFFFF80, 4'b1000, 0, 0};
      vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0, 32'h80F17F01, 1, 32'h00000080, 4'b1000, 0, 0};
      vecs[3]  = '{1, 0, 3'b001, 32'h102, 32'h0, 32'h80F17F01, 0, 32'hFFFF80F1, 4'b1100, 0, 0};
      vecs[4]  = '{1, 0, 3'b101, 32'h102, 32'h0, 32'h80F17F01, 2, 32'h000080F1, 4'b1100, 0, 0};
      vecs[5]  = '{0, 1, 3'b000, 32'h201, 32'hAB, 32'h0, 0, 32'h000080F1, 4'b0010, 0, 0};
      vecs[6]  = '{0, 1, 3'b001, 32'h203, 32'h1234, 32'h0, 0, 32'h000080F1, 4'b0000, 1, 0};
      vecs[7]  = '{1, 0, 3'b010, 32'h104, 32'h0, 32'h55555555, -1, 32'h0, 4'b1111, 0, 1};
      vecs[8]  = '{1, 0, 3'b010, 32'h108, 32'h0, 32'h12345678, 3, 32'h12345678, 4'b1111, 0, 0};
      vecs[9]  = '{0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2, 32'h12345678, 4'b1111, 0, 0};
      vecs[10] = '{1, 0, 3'b000, 32'h101, 32'h0, 32'h80F17F01, 1, 32'h0000007F, 4'b0010, 0, 0};
      vecs[11] = '{1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 32'h0000007F, 4'b0000, 1, 0};
      vecs[12] = '{1, 1, 3'b010, 32'h204, 32'h11223344, 32'hFFFFFFFF, 0, 32'h0000007F, 4'b1111,
                   0, 0};
      vecs[13] = '{0, 1, 3'b001, 32'h200, 32'hBEEF, 32'h0, -1, 32'h0000007F, 4'b0011, 0, 1};
      vecs[14] = '{1, 0, 3'b001, 32'h100, 32'h0, 32'h80F17F01, 0, 32'h00007F01, 4'b0011, 0, 0};
      vecs[15] = '{0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 32'h00007F01, 4'b1100, 0, 0};

      reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      m_ack = 0; m_rdata = 0;
      @(negedge clk);
      chk("reset read_data", read_data, 32'h0);
      chk("reset flags", {27'h0, done, misalign, bus_err, m_req, m_we}, 32'h0);
      chk("reset m_be", 32'(m_be), 32'h0);
      chk("reset m_addr", m_addr, 32'h0);
      chk("reset m_wdata", m_wdata, 32'h0);
      chk("reset stall", 32'(stall), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) run(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a BUSY access that would need three wait states.
      mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h180; m_ack = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midbusy m_req_before", 32'(m_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midbusy m_req_async_drop", 32'(m_req), 32'd0);
      chk("midbusy no_done", 32'(done), 32'd0);
      mem_read = 0;
      @(negedge clk);
      reset = 1'b0;
      done_hits = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) done_hits++;
      end
      chk("midbusy done_after_reset", done_hits, 0);
      chk("midbusy m_req_idle", 32'(m_req), 32'd0);
      @(posedge clk); #1;
      post = '{1, 0, 3'b010, 32'h400, 32'h0, 32'hA5A55A5A, 0, 32'hA5A55A5A, 4'b1111, 0, 0};
      run(post, "post_reset_lw");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
